uart_line_editor: RTL

//  Line-editing stage between uart_rx_buf (upstream) and uart_tx_buf (downstream).

---
 rtl/uart_line_editor_pkg.sv | 23 ++
 rtl/uart_line_editor_line_buf_ram.sv | 28 ++
 rtl/uart_line_editor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_line_editor_pkg.sv
// Shared definitions for the UART line editor: ASCII codes, FSM states and
// the saturating counter helper.
package uart_line_editor_pkg;

  localparam logic [7:0] ASC_BEL = 8'h07;
  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_TLD = 8'h7E;
  localparam logic [7:0] ASC_DEL = 8'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ECHO = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_line_editor_line_buf_ram.sv
// Line buffer: single write port, single registered read port (BRAM friendly).
module line_buf_ram
  import uart_line_editor_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int RAM_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [RAM_AW-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [RAM_AW-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_rdata <= '0;
    else     o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/uart_line_editor.sv
// Line editor between the UART RX and TX buffers: echoes input, handles
// backspace/delete, collects a line and holds it until the consumer acks.
module uart_line_editor
  import uart_line_editor_pkg::*;
#(
  parameter int LINE_LEN = 64,
  parameter int AW       = $clog2(LINE_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          rx_get,
  input  logic [7:0]    rx_data,
  input  logic          rx_empty,
  output logic          tx_put,
  output logic [7:0]    tx_data,
  input  logic          tx_full,
  output logic          line_valid,
  output logic [AW-1:0] line_len,
  input  logic          line_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    overflow_cnt
);

  localparam int            RAM_AW   = $clog2(LINE_LEN);
  localparam logic [AW-1:0] FULL_LEN = AW'(LINE_LEN);

  state_t        r_state, w_next;
  logic          r_live;
  logic [AW-1:0] r_len, r_line_len;
  logic [7:0]    r_ovf;
  logic [23:0]   r_seq;
  logic [1:0]    r_cnt;
  logic          r_seq_cr;

  logic              w_consume, w_full, w_print, w_erase, w_cr;
  logic              w_store, w_load;
  logic [23:0]       w_seq;
  logic [1:0]        w_cnt;
  logic [RAM_AW-1:0] w_raddr;

  // r_live keeps rx_get low during and right after reset.
  assign rx_get       = r_live && (r_state == S_IDLE);
  assign tx_put       = (r_state == S_ECHO) && !tx_full;
  assign tx_data      = r_seq[23:16];
  assign line_valid   = (r_state == S_DONE);
  assign line_len     = r_line_len;
  assign overflow_cnt = r_ovf;

  always_comb begin
    w_consume = rx_get && !rx_empty;
    w_full    = (r_len == FULL_LEN);
    w_print   = (rx_data >= ASC_SP) && (rx_data <= ASC_TLD);
    w_erase   = (rx_data == ASC_BS) || (rx_data == ASC_DEL);
    w_cr      = (rx_data == ASC_CR);
    w_store   = w_consume && w_print && !w_full;
    w_load    = w_consume && (w_print || w_erase || w_cr);
    w_seq     = '0;
    w_cnt     = 2'd0;
    if (w_print) begin
      w_seq = {(w_full ? ASC_BEL : rx_data), 16'h0000};
      w_cnt = 2'd1;
    end else if (w_erase) begin
      w_seq = (r_len != '0) ? {ASC_BS, ASC_SP, ASC_BS} : {ASC_BEL, 16'h0000};
      w_cnt = (r_len != '0) ? 2'd3 : 2'd1;
    end else if (w_cr) begin
      w_seq = {ASC_CR, ASC_LF, 8'h00};
      w_cnt = 2'd2;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_next = S_ECHO;
      S_ECHO:  if (tx_put && r_cnt == 2'd1) w_next = r_seq_cr ? S_DONE : S_IDLE;
      S_DONE:  if (line_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_line_len <= '0;
      r_ovf      <= '0;
      r_seq      <= '0;
      r_cnt      <= '0;
      r_seq_cr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_seq    <= w_seq;
        r_cnt    <= w_cnt;
        r_seq_cr <= w_cr;
      end else if (tx_put) begin
        r_seq <= {r_seq[15:0], 8'h00};
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_store)
        r_len <= r_len + AW'(1);
      else if (w_consume && w_erase && r_len != '0)
        r_len <= r_len - AW'(1);
      else if (line_valid && line_ack)
        r_len <= '0;
      if (w_consume && w_cr) r_line_len <= r_len;
      if (w_consume && w_print && w_full) r_ovf <= sat_inc8(r_ovf);
    end
  end

  // Reads past the end of the buffer are undefined; fold them onto entry 0.
  assign w_raddr = (rd_addr >= FULL_LEN) ? '0 : rd_addr[RAM_AW-1:0];

  line_buf_ram #(
    .DEPTH  (LINE_LEN),
    .RAM_AW (RAM_AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_store),
    .i_waddr (r_len[RAM_AW-1:0]),
    .i_wdata (rx_data),
    .i_raddr (w_raddr),
    .o_rdata (rd_data)
  );

endmodule
